nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder/subtractor built around a single 4-bit ripple slice.
// One nibble per cycle, LSB first. Response is held stable until the valid/ready handshake completes.

module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]      nib_a, nib_b, nib_sum;
  logic            nib_cout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state == IDLE);
    resp_valid_o = (state == DONE);
  end

  assign nib_a = a_q[{cnt, 2'b00} +: 4];
  assign nib_b = b_q[{cnt, 2'b00} +: 4];

  fulladder4 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // B is stored pre-inverted for subtract, so the slice only ever adds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          a_q     <= a_i;
          b_q     <= b_i ^ {WIDTH{sub_i}};
          carry_q <= sub_i;
          cnt     <= '0;
        end
        CALC: begin
          res_q[{cnt, 2'b00} +: 4] <= nib_sum;
          carry_q                  <= nib_cout;
          cnt                      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum_o      = res_q;
  assign carry_o    = carry_q;
  assign overflow_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
  assign zero_o     = ~|res_q;

endmodule
